ram_fifo_ctrl: RTL and testbench

- FIFO controller sitting directly upstream of the dual-port `ram`; drives its write and read ports and consumes its `rd_data`.
- Converts the RAM into a show-ahead FIFO with valid/ready push and pop interfaces.
- Owns the write/read pointers, full/empty flags, occupancy, and a 2-entry output buffer that hides the RAM's 1-cycle read latency.
- RAM contract: write on the clock edge when `wr_enb`=1; `rd_data` is valid the cycle after the edge that samples `rd_enb`/`rd_addr`.

---
 rtl/ram_fifo_pkg.sv | 12 +
 rtl/ram_fifo_out_buf.sv | 72 +++++++
 rtl/ram_fifo_ctrl.sv | 92 +++++++++
 tb/tb_ram_fifo_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared defaults and types for the RAM-backed show-ahead FIFO controller.

package ram_fifo_pkg;

   localparam int unsigned FIFO_DATA_WIDTH = 8;
   localparam int unsigned FIFO_ADDR_WIDTH = 4;
   localparam int unsigned FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;

   // One extra bit over the address so full and empty stay distinguishable.
   typedef logic [FIFO_ADDR_WIDTH:0] ptr_t;

endpackage

// File: rtl/ram_fifo_out_buf.sv
// Two-entry in-order output buffer; hides the RAM read latency so the FIFO head
// is presented combinationally (show-ahead).

module ram_fifo_out_buf
   import ram_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [1:0]            count,
   output logic [DATA_WIDTH-1:0] head_data
);

   logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
   logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
   logic [1:0]            count_q, count_d;
   logic                  rd_ok;

   assign rd_ok = rd_en && (count_q != 2'd0);

   always_comb begin
      ent0_d  = ent0_q;
      ent1_d  = ent1_q;
      count_d = count_q;
      if (clear) begin
         count_d = 2'd0;
      end else begin
         case ({wr_en, rd_ok})
            2'b10: begin
               if (count_q == 2'd0) ent0_d = wr_data;
               else                 ent1_d = wr_data;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               ent0_d  = ent1_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               // Occupancy unchanged: the new word lands behind whatever remains.
               if (count_q == 2'd1) begin
                  ent0_d = wr_data;
               end else begin
                  ent0_d = ent1_q;
                  ent1_d = wr_data;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ent0_q  <= '0;
         ent1_q  <= '0;
         count_q <= 2'd0;
      end else begin
         ent0_q  <= ent0_d;
         ent1_q  <= ent1_d;
         count_q <= count_d;
      end
   end

   assign count     = count_q;
   assign head_data = ent0_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Show-ahead FIFO controller driving a dual-port RAM with 1-cycle read latency;
// owns pointers, flags, occupancy and the output buffer.

module ram_fifo_ctrl
   import ram_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push_valid,
   output logic                  push_ready,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  pop_valid,
   input  logic                  pop_ready,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  ram_wr_enb,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic                  ram_rd_enb,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic [ADDR_WIDTH+1:0] level,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned PW = ADDR_WIDTH + 1;
   localparam int unsigned LW = ADDR_WIDTH + 2;
   localparam logic [PW-1:0] DEPTH_CNT = PW'(2 ** ADDR_WIDTH);

   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW-1:0] ram_cnt;
   logic          inflight_q;
   logic [1:0]    out_cnt;
   logic [2:0]    occ;
   logic          push_fire, pop_fire, rd_issue;

   assign ram_cnt    = wr_ptr_q - rd_ptr_q;
   assign push_ready = (ram_cnt != DEPTH_CNT) && !flush;
   assign push_fire  = push_valid && push_ready;

   assign pop_valid = (out_cnt != 2'd0);
   assign pop_fire  = pop_valid && pop_ready;

   // A read may issue only if its result is guaranteed a buffer slot on arrival.
   assign occ      = {1'b0, out_cnt} + {2'b00, inflight_q};
   assign rd_issue = (ram_cnt != '0) && (occ < (3'd2 + {2'b00, pop_fire})) && !flush;

   // Gated by reset so a held push_valid cannot strobe the RAM during reset.
   assign ram_wr_enb  = push_fire && rst;
   assign ram_wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
   assign ram_wr_data = push_data;
   assign ram_rd_enb  = rd_issue;
   assign ram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         inflight_q <= 1'b0;
      end else if (flush) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         inflight_q <= 1'b0;
      end else begin
         if (push_fire) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (rd_issue)  rd_ptr_q <= rd_ptr_q + PW'(1);
         inflight_q <= rd_issue;
      end
   end

   ram_fifo_out_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_buf (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .wr_en     (inflight_q),
      .wr_data   (ram_rd_data),
      .rd_en     (pop_fire),
      .count     (out_cnt),
      .head_data (pop_data)
   );

   assign level = LW'(ram_cnt) + LW'(inflight_q) + LW'(out_cnt);
   assign full  = !push_ready;
   assign empty = (level == '0);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl: behavioural RAM, queue reference model,
// directed latency/fill/stall/flush/reset scenarios plus randomized traffic.

module tb_ram_fifo_ctrl;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int CAP   = DEPTH + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          push_valid = 1'b0;
   logic          pop_ready = 1'b0;
   logic [DW-1:0] push_data = '0;
   logic          push_ready, pop_valid, full, empty;
   logic [DW-1:0] pop_data, ram_wr_data, ram_rd_data;
   logic          ram_wr_enb, ram_rd_enb;
   logic [AW-1:0] ram_wr_addr, ram_rd_addr;
   logic [AW+1:0] level;

   int n_checks = 0;
   int n_fail   = 0;

   ram_fifo_ctrl #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .push_valid  (push_valid),
      .push_ready  (push_ready),
      .push_data   (push_data),
      .pop_valid   (pop_valid),
      .pop_ready   (pop_ready),
      .pop_data    (pop_data),
      .ram_wr_enb  (ram_wr_enb),
      .ram_wr_addr (ram_wr_addr),
      .ram_wr_data (ram_wr_data),
      .ram_rd_enb  (ram_rd_enb),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data),
      .level       (level),
      .full        (full),
      .empty       (empty)
   );

   always #5 clk = ~clk;

   // Behavioural dual-port RAM: synchronous write, 1-cycle registered read, never cleared.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (ram_wr_enb) mem[ram_wr_addr] <= ram_wr_data;
      if (ram_rd_enb) ram_rd_data <= mem[ram_rd_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: accepted words queue up in order; every pop must match the front.
   logic [DW-1:0] exp_q[$];
   int            model_cnt = 0;
   int            pops_seen = 0;
   logic          hold_prev = 1'b0;
   logic [DW-1:0] hold_data = '0;

   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         model_cnt = 0;
         hold_prev = 1'b0;
      end else begin
         check("level", 32'(level), 32'(model_cnt));
         check("empty", 32'(empty), 32'(model_cnt == 0));
         check("full", 32'(full), 32'(!push_ready));
         check("wr_enb", 32'(ram_wr_enb), 32'(push_valid && push_ready));
         if (model_cnt >= CAP) check("push_ready_at_cap", 32'(push_ready), 32'd0);
         if (model_cnt < DEPTH && !flush) check("push_ready_room", 32'(push_ready), 32'd1);
         if (model_cnt == 0) check("pop_valid_when_empty", 32'(pop_valid), 32'd0);
         if (hold_prev) begin
            check("hold_valid", 32'(pop_valid), 32'd1);
            check("hold_data", 32'(pop_data), 32'(hold_data));
         end
         if (flush) begin
            check("push_ready_in_flush", 32'(push_ready), 32'd0);
            exp_q.delete();
            model_cnt = 0;
            hold_prev = 1'b0;
         end else begin
            if (pop_valid && pop_ready) begin
               if (exp_q.size() == 0) begin
                  check("pop_unexpected", 32'(pop_valid), 32'd0);
               end else begin
                  check("pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
                  model_cnt--;
               end
               pops_seen++;
            end
            if (push_valid && push_ready) begin
               exp_q.push_back(push_data);
               model_cnt++;
            end
            hold_prev = pop_valid && !pop_ready;
            hold_data = pop_data;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      push_valid = 1'b0;
      pop_ready  = 1'b1;
      for (int k = 0; k < 80 && !empty; k++) tick();
      tick();
      check(name, 32'(empty), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int acc;
      int p0;
      int i;
      int cyc;
      logic pr;

      // Reset with push_valid held high: the RAM must not be strobed.
      push_valid = 1'b1;
      push_data  = 8'h5A;
      repeat (2) @(posedge clk);
      #1;
      check("rst_push_ready", 32'(push_ready), 32'd1);
      check("rst_pop_valid", 32'(pop_valid), 32'd0);
      check("rst_pop_data", 32'(pop_data), 32'd0);
      check("rst_wr_enb", 32'(ram_wr_enb), 32'd0);
      check("rst_rd_enb", 32'(ram_rd_enb), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      push_valid = 1'b0;
      rst = 1'b1;
      tick();

      // Single push: visible at pop after edge N+2.
      push_valid = 1'b1;
      push_data  = 8'hA5;
      pop_ready  = 1'b1;
      #1;
      check("t1_wr_enb", 32'(ram_wr_enb), 32'd1);
      check("t1_wr_addr", 32'(ram_wr_addr), 32'd0);
      check("t1_wr_data", 32'(ram_wr_data), 32'hA5);
      @(posedge clk); #1;
      push_valid = 1'b0;
      check("t1_valid_n", 32'(pop_valid), 32'd0);
      check("t1_rd_enb", 32'(ram_rd_enb), 32'd1);
      check("t1_rd_addr", 32'(ram_rd_addr), 32'd0);
      tick();
      check("t1_valid_n1", 32'(pop_valid), 32'd0);
      tick();
      check("t1_valid_n2", 32'(pop_valid), 32'd1);
      check("t1_data_n2", 32'(pop_data), 32'hA5);
      tick();
      check("t1_level_after", 32'(level), 32'd0);

      // Fill to capacity with no consumer.
      pop_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 60; c++) begin
         push_valid = 1'b1;
         push_data  = DW'(acc);
         #1;
         if (!push_ready) break;
         @(posedge clk); #1;
         acc++;
      end
      check("t2_accepted", 32'(acc), 32'(CAP));
      check("t2_level", 32'(level), 32'(CAP));
      check("t2_full", 32'(full), 32'd1);
      push_data = 8'hEE;
      tick();
      tick();
      check("t2_level_hold", 32'(level), 32'(CAP));
      p0 = pops_seen;
      drain("t2_drained");
      check("t2_pop_count", 32'(pops_seen - p0), 32'(CAP));

      // Streaming: one push and one pop per cycle, pointers wrap.
      pop_ready = 1'b1;
      p0 = pops_seen;
      i = 0;
      cyc = 0;
      for (cyc = 0; cyc < 120; cyc++) begin
         push_valid = (i < 40);
         push_data  = DW'(i);
         #1;
         pr = push_ready;
         @(posedge clk); #1;
         if (push_valid && pr) i++;
         if (pops_seen - p0 >= 40) break;
      end
      check("t3_pushes", 32'(i), 32'd40);
      check("t3_last_pop_edge", 32'(cyc), 32'd42);
      drain("t3_drained");

      // Stall with a full output buffer: head must hold and reads must stop.
      pop_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         push_valid = 1'b1;
         push_data  = DW'(8'h10 + k);
         tick();
      end
      push_valid = 1'b0;
      repeat (4) tick();
      check("t4_level", 32'(level), 32'd4);
      check("t4_head", 32'(pop_data), 32'h10);
      pop_ready = 1'b1;
      #1;
      check("t4_refill_issue", 32'(ram_rd_enb), 32'd1);
      tick();
      pop_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("t4_stall_data", 32'(pop_data), 32'h11);
         check("t4_stall_rd", 32'(ram_rd_enb), 32'd0);
         tick();
      end
      check("t4_level_after", 32'(level), 32'd3);
      drain("t4_drained");

      // Flush while a read is in flight.
      pop_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         push_valid = 1'b1;
         push_data  = DW'(8'h20 + k);
         tick();
      end
      push_valid = 1'b0;
      repeat (4) tick();
      pop_ready = 1'b1;
      tick();
      pop_ready  = 1'b0;
      flush      = 1'b1;
      push_valid = 1'b1;
      push_data  = 8'h77;
      #1;
      check("t5_level_pre", 32'(level), 32'd4);
      check("t5_flush_ready", 32'(push_ready), 32'd0);
      check("t5_flush_wr", 32'(ram_wr_enb), 32'd0);
      check("t5_flush_rd", 32'(ram_rd_enb), 32'd0);
      tick();
      flush      = 1'b0;
      push_valid = 1'b0;
      check("t5_empty", 32'(empty), 32'd1);
      check("t5_level", 32'(level), 32'd0);
      check("t5_pop_valid", 32'(pop_valid), 32'd0);
      tick();
      check("t5_discarded", 32'(pop_valid), 32'd0);
      push_valid = 1'b1;
      push_data  = 8'h3C;
      #1;
      check("t5_wr_addr", 32'(ram_wr_addr), 32'd0);
      tick();
      push_valid = 1'b0;
      for (int k = 0; k < 10 && !pop_valid; k++) tick();
      check("t5_readback", 32'(pop_data), 32'h3C);
      drain("t5_drained");

      // Randomized traffic with occasional flushes.
      for (int k = 0; k < 400; k++) begin
         push_valid = ($urandom % 4) != 0;
         push_data  = DW'($urandom);
         pop_ready  = ($urandom % 3) != 0;
         flush      = ($urandom % 64) == 0;
         tick();
      end
      flush = 1'b0;

      // Asynchronous reset between edges, with traffic still being offered.
      push_valid = 1'b1;
      pop_ready  = 1'b0;
      repeat (6) tick();
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("t6_pop_valid", 32'(pop_valid), 32'd0);
      check("t6_wr_enb", 32'(ram_wr_enb), 32'd0);
      check("t6_rd_enb", 32'(ram_rd_enb), 32'd0);
      check("t6_level", 32'(level), 32'd0);
      push_valid = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      tick();
      check("t6_empty", 32'(empty), 32'd1);

      // Short random burst after reset to confirm normal operation resumes.
      for (int k = 0; k < 100; k++) begin
         push_valid = ($urandom % 2) != 0;
         push_data  = DW'($urandom);
         pop_ready  = ($urandom % 4) != 0;
         tick();
      end
      drain("final_drained");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
